// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
//   Bundles the request/response signals of the IF and MEM requesters, the
//   external SRAM port and the pipeline stall requests into one interface.
//
//   master : the arbiter itself (receives requests, drives the SRAM port,
//            acks and stall requests).
//   slave  : the surroundings (IF stage, MEM stage, SRAM, pipeline control).
//
//   Handshake rules, shared by every request/ack pair in this interface:
//     - A requester raises x_req and holds it high, with its address and
//       payload stable, until it sees x_ack. x_ack is a one-cycle pulse; the
//       read data (x_rdata) is valid in that cycle and held until the next
//       x_ack. The requester drops or replaces its request in the ack cycle.
//     - bus_req is high for the whole SRAM access and qualifies bus_we,
//       bus_sel, bus_addr and bus_wdata. The SRAM answers with a one-cycle
//       bus_ack (bus_rdata valid in that cycle), only while bus_req is high.
interface sram_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  logic        stallreq_if;
  logic        stallreq_mem;
  logic        bus_err;

  modport master (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    input  bus_rdata, bus_ack,
    output if_rdata, if_ack, mem_rdata, mem_ack,
    output bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    output stallreq_if, stallreq_mem, bus_err
  );

  modport slave (
    output if_req, if_addr,
    output mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    output bus_rdata, bus_ack,
    input  if_rdata, if_ack, mem_rdata, mem_ack,
    input  bus_req, bus_we, bus_sel, bus_addr, bus_wdata,
    input  stallreq_if, stallreq_mem, bus_err
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares the single external SRAM port between instruction fetch (IF) and
//   the MEM stage. A granted request is registered onto the bus, the arbiter
//   waits for a variable-latency bus_ack (or a timeout), then returns a
//   one-cycle ack plus read data to the winner. Stall requests to the
//   pipeline are combinational.
//
//   Ports:
//     clk       system clock, all state on the rising edge
//     rst       asynchronous, active-low reset
//     p         sram_port_arbiter_if.master: IF/MEM requests, SRAM port,
//               acks, stall requests, bus_err
//     dbg_state current FSM state (0 IDLE, 1 BUSY_IF, 2 BUSY_MEM, 3 DONE)
//
//   Parameters:
//     TIMEOUT_CYCLES  busy cycles to wait for bus_ack before aborting (1..255)
//     ERR_RDATA       read data returned on a timed-out access
module sram_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  sram_port_arbiter_if.master         p,
  output logic [1:0]                  dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Counter value in the last busy cycle before the access is aborted.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [3:0]  bus_sel_q, bus_sel_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic        bus_err_q, bus_err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_mem_q, last_mem_d;   // 1: last grant went to MEM
  logic        grant_mem;
  logic        grant_if;

  // MEM normally wins; after a MEM grant a waiting IF goes first so fetch
  // cannot be starved by back-to-back loads/stores.
  assign grant_mem = p.mem_req & (~p.if_req | ~last_mem_q);
  assign grant_if  = p.if_req & ~grant_mem;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    bus_err_d   = 1'b0;
    cnt_d       = cnt_q;
    last_mem_d  = last_mem_q;

    unique case (state_q)
      IDLE: begin
        if (grant_mem) begin
          bus_req_d   = 1'b1;
          bus_we_d    = p.mem_we;
          bus_sel_d   = p.mem_sel;
          bus_addr_d  = p.mem_addr;
          bus_wdata_d = p.mem_wdata;
          cnt_d       = 8'd0;
          last_mem_d  = 1'b1;
          state_d     = BUSY_MEM;
        end else if (grant_if) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_sel_d   = 4'hF;
          bus_addr_d  = p.if_addr;
          bus_wdata_d = 32'd0;
          cnt_d       = 8'd0;
          last_mem_d  = 1'b0;
          state_d     = BUSY_IF;
        end
      end

      BUSY_IF: begin
        if (p.bus_ack) begin
          if_rdata_d = p.bus_rdata;
          if_ack_d   = 1'b1;
          bus_req_d  = 1'b0;
          state_d    = DONE;
        end else if (cnt_q == TO_LAST) begin
          if_rdata_d = ERR_RDATA;
          if_ack_d   = 1'b1;
          bus_err_d  = 1'b1;
          bus_req_d  = 1'b0;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      BUSY_MEM: begin
        // Stores complete without touching the held load data.
        if (p.bus_ack) begin
          if (!bus_we_q) mem_rdata_d = p.bus_rdata;
          mem_ack_d = 1'b1;
          bus_req_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == TO_LAST) begin
          if (!bus_we_q) mem_rdata_d = ERR_RDATA;
          mem_ack_d = 1'b1;
          bus_err_d = 1'b1;
          bus_req_d = 1'b0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      // Ack cycle: requesters drop or change their request here, so no new
      // grant is taken until IDLE.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= 4'd0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      cnt_q       <= 8'd0;
      last_mem_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
      last_mem_q  <= last_mem_d;
    end
  end

  assign p.bus_req      = bus_req_q;
  assign p.bus_we       = bus_we_q;
  assign p.bus_sel      = bus_sel_q;
  assign p.bus_addr     = bus_addr_q;
  assign p.bus_wdata    = bus_wdata_q;
  assign p.if_rdata     = if_rdata_q;
  assign p.mem_rdata    = mem_rdata_q;
  assign p.if_ack       = if_ack_q;
  assign p.mem_ack      = mem_ack_q;
  assign p.bus_err      = bus_err_q;
  assign p.stallreq_if  = p.if_req & ~if_ack_q;
  assign p.stallreq_mem = p.mem_req & ~mem_ack_q;
  assign dbg_state      = state_q;

endmodule
